bram_bank_array: RTL and testbench
==================================

# bram_bank_array

Multi-bank, simple dual-port block RAM for the convolutor line buffers; the parametrised successor of the single-bank image memory. NB_BANKS independent banks share one read address and are read in parallel, one word per bank, so a K-row kernel window gets one column per cycle. Writes target one selected bank. A hardware fill engine writes FILL_VALUE to every location after reset or on request, replacing simulation-only initial blocks.

## Interface
- RAM_WIDTH, 13, word width in bits
- NB_ADDRESS, 10, address width; depth per bank = 2**NB_ADDRESS (full range, all addresses valid)
- NB_BANKS, 3, number of banks (>=1)
- FILL_VALUE, {RAM_WIDTH{1'b1}}, word written by the fill engine
- RD_MODE, 0, same-address collision: 0 = read-first (old data), 1 = write-first (new data)
- NB_BANK_SEL, derived localparam, max(1, clog2(NB_BANKS))

- i_CLK  in  1  clock, all logic on rising edge
- i_rst  in  1  asynchronous reset, active-low
- i_clear  in  1  one-cycle pulse, start/restart fill of all banks
- o_busy  out  1  high while fill in progress
- i_wrEnable  in  1  write strobe
- i_wrBank  in  NB_BANK_SEL  target bank of write
- i_writeAdd  in  NB_ADDRESS  write address
- i_data  in  RAM_WIDTH  write data
- i_rdEnable  in  1  read strobe
- i_readAdd  in  NB_ADDRESS  read address, common to all banks
- o_data  out  NB_BANKS*RAM_WIDTH  bank b at bits [b*RAM_WIDTH +: RAM_WIDTH]
- o_valid  out  1  o_data updated this cycle

## Operation
- FSM states: FILL, IDLE. Reset (i_rst low) forces FILL, fill counter = 0, o_busy = 1, o_valid = 0, o_data = 0.
- FILL: each cycle write FILL_VALUE at counter address in all banks, counter +1; at counter = 2**NB_ADDRESS-1 write last location and go IDLE next cycle. o_busy = 1 throughout FILL.
- IDLE: o_busy = 0. i_clear -> FILL with counter = 0.
- i_clear during FILL: counter restarts at 0.
- i_wrEnable, i_rdEnable ignored while o_busy = 1 (no write, o_valid stays 0).
- i_clear and i_wrEnable same cycle in IDLE: clear wins, write dropped.
- Write: i_wrEnable in IDLE with i_wrBank < NB_BANKS writes i_data to that bank; i_wrBank >= NB_BANKS drops write silently.
- Read: i_rdEnable in IDLE latches all banks at i_readAdd into o_data; o_valid = 1 next cycle. Without accepted read, o_data holds previous value, o_valid = 0.
- Collision (read and write same cycle, same address): written bank returns old word if RD_MODE = 0, i_data if RD_MODE = 1; other banks return stored word.
- No arithmetic on data; address counter is NB_ADDRESS+1 bits wide to detect terminal count without wrap ambiguity.

## Timing
- Read latency 1 cycle: strobe at edge n, o_data/o_valid valid after edge n+1.
- Back-to-back reads every cycle; o_valid stays high.
- Write visible to a read issued the cycle after the write edge.
- Fill duration 2**NB_ADDRESS cycles; o_busy falls on the edge after the last fill write.
- Asynchronous reset mid-fill or mid-read: outputs to reset values immediately; memory contents undefined until the fill completes.

## Structure
- Shared package: FSM state encoding (FILL, IDLE), RD_MODE constants (RD_FIRST = 0, WR_FIRST = 1), clog2 function.
- Sub-module bram_bank_core: one simple dual-port bank with registered output and RD_MODE collision handling, generated NB_BANKS times. The top level holds the FSM, fill counter, write-port mux (fill vs user), bank decode and o_valid.

## Test plan
- Reset release, NB_ADDRESS = 4: o_busy = 1 for 16 cycles then 0; reading addresses 0..15 returns 13'h1FFF in all 3 banks.
- Write 13'h0A5 bank 1 addr 7, then read addr 7: o_data = {13'h1FFF, 13'h0A5, 13'h1FFF}, o_valid one cycle after the strobe.
- Same-cycle read and write addr 3, bank 0, data 13'h012: RD_MODE = 0 returns 13'h1FFF; RD_MODE = 1 returns 13'h012.
- Write with i_wrBank = 3 (NB_BANKS = 3): no bank changes; a read of that address returns 13'h1FFF everywhere.
- i_clear at counter = 9 during fill: o_busy stays high 16 more cycles. Writes and reads during busy are ignored and o_valid stays 0.
- i_rst low in the middle of a read burst: o_valid and o_data go to 0 asynchronously, and a full fill restarts.

Source files
------------

// File: rtl/bram_bank_array_pkg.sv
// Shared definitions for the multi-bank line-buffer RAM:
// FSM state encoding, collision-mode constants and width helpers.
package bram_bank_array_pkg;

  // Fill engine / normal operation states.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  // Same-address read/write collision behaviour.
  localparam int unsigned RD_FIRST = 0;
  localparam int unsigned WR_FIRST = 1;

  // Ceiling log2 for elaboration-time width computation.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((33'd1 << i) < 33'(value)) result = i + 1;
    end
    return result;
  endfunction

  // Bank-select width; at least one bit even for a single bank.
  function automatic int unsigned bank_sel_w(input int unsigned nb_banks);
    return (clog2(nb_banks) > 1) ? clog2(nb_banks) : 1;
  endfunction

endpackage

// File: rtl/bram_bank_core.sv
// One simple dual-port RAM bank with a registered read port.
// Ports:
//   clk, rst_n          clock, async active-low reset (clears read register only)
//   we, waddr, wdata    write port
//   re, raddr           read strobe and address
//   rdata               registered read data, holds when re is low
module bram_bank_core
  import bram_bank_array_pkg::*;
#(
  parameter int unsigned RAM_WIDTH  = 13,
  parameter int unsigned NB_ADDRESS = 10,
  parameter int unsigned RD_MODE    = RD_FIRST
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [NB_ADDRESS-1:0] waddr,
  input  logic [RAM_WIDTH-1:0]  wdata,
  input  logic                  re,
  input  logic [NB_ADDRESS-1:0] raddr,
  output logic [RAM_WIDTH-1:0]  rdata
);

  localparam int unsigned DEPTH = 2 ** NB_ADDRESS;

  logic [RAM_WIDTH-1:0] mem [DEPTH];
  logic                 bypass;

  // Write-first mode forwards the incoming word on a same-address hit.
  assign bypass = (RD_MODE == WR_FIRST) && we && (waddr == raddr);

  // Storage array, no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= bypass ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/bram_bank_array.sv
// Multi-bank line-buffer RAM: NB_BANKS banks read in parallel at a shared
// address, written one bank at a time, with a fill engine that writes
// FILL_VALUE everywhere after reset or on i_clear.
// Ports:
//   i_CLK, i_rst                 clock, async active-low reset
//   i_clear / o_busy             start fill / fill in progress
//   i_wrEnable, i_wrBank,
//   i_writeAdd, i_data           user write port (one bank)
//   i_rdEnable, i_readAdd        user read port (all banks)
//   o_data, o_valid              bank b at [b*RAM_WIDTH +: RAM_WIDTH], valid pulse
module bram_bank_array
  import bram_bank_array_pkg::*;
#(
  parameter int unsigned          RAM_WIDTH   = 13,
  parameter int unsigned          NB_ADDRESS  = 10,
  parameter int unsigned          NB_BANKS    = 3,
  parameter logic [RAM_WIDTH-1:0] FILL_VALUE  = {RAM_WIDTH{1'b1}},
  parameter int unsigned          RD_MODE     = RD_FIRST,
  localparam int unsigned         NB_BANK_SEL = bank_sel_w(NB_BANKS)
) (
  input  logic                          i_CLK,
  input  logic                          i_rst,
  input  logic                          i_clear,
  output logic                          o_busy,
  input  logic                          i_wrEnable,
  input  logic [NB_BANK_SEL-1:0]        i_wrBank,
  input  logic [NB_ADDRESS-1:0]         i_writeAdd,
  input  logic [RAM_WIDTH-1:0]          i_data,
  input  logic                          i_rdEnable,
  input  logic [NB_ADDRESS-1:0]         i_readAdd,
  output logic [NB_BANKS*RAM_WIDTH-1:0] o_data,
  output logic                          o_valid
);

  localparam int unsigned      CNT_W = NB_ADDRESS + 1;
  localparam int unsigned      DEPTH = 2 ** NB_ADDRESS;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEPTH - 1);

  state_t                state;
  state_t                next_state;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      cnt_next;
  logic                  busy_next;
  logic                  fill_we;
  logic                  user_we;
  logic                  rd_accept;
  logic [NB_ADDRESS-1:0] waddr;
  logic [RAM_WIDTH-1:0]  wdata;
  logic [NB_BANKS-1:0]   bank_we;

  // State, fill counter and registered status outputs.
  always_ff @(posedge i_CLK or negedge i_rst) begin
    if (!i_rst) begin
      state   <= ST_FILL;
      cnt     <= '0;
      o_busy  <= 1'b1;
      o_valid <= 1'b0;
    end else begin
      state   <= next_state;
      cnt     <= cnt_next;
      o_busy  <= busy_next;
      o_valid <= rd_accept;
    end
  end

  // Next-state, counter and port-acceptance decode.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    fill_we    = 1'b0;
    user_we    = 1'b0;
    rd_accept  = 1'b0;
    case (state)
      ST_FILL: begin
        fill_we = 1'b1;
        if (i_clear) begin
          cnt_next = '0;
        end else if (cnt == LAST) begin
          cnt_next   = '0;
          next_state = ST_IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        rd_accept = i_rdEnable;
        if (i_clear) begin
          // Clear takes priority; a same-cycle write is dropped.
          next_state = ST_FILL;
          cnt_next   = '0;
        end else begin
          user_we = i_wrEnable && (32'(i_wrBank) < NB_BANKS);
        end
      end
      default: next_state = ST_FILL;
    endcase
    busy_next = (next_state == ST_FILL);
  end

  // Shared write port: fill engine hits every bank, user write one bank.
  always_comb begin
    waddr   = fill_we ? cnt[NB_ADDRESS-1:0] : i_writeAdd;
    wdata   = fill_we ? FILL_VALUE : i_data;
    bank_we = '0;
    for (int unsigned b = 0; b < NB_BANKS; b++) begin
      bank_we[b] = fill_we || (user_we && (i_wrBank == NB_BANK_SEL'(b)));
    end
  end

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
    bram_bank_core #(
      .RAM_WIDTH (RAM_WIDTH),
      .NB_ADDRESS(NB_ADDRESS),
      .RD_MODE   (RD_MODE)
    ) u_core (
      .clk  (i_CLK),
      .rst_n(i_rst),
      .we   (bank_we[b]),
      .waddr(waddr),
      .wdata(wdata),
      .re   (rd_accept),
      .raddr(i_readAdd),
      .rdata(o_data[b*RAM_WIDTH +: RAM_WIDTH])
    );
  end

endmodule

// File: tb/tb_bram_bank_array.sv
// Self-checking bench for bram_bank_array (NB_ADDRESS = 4, 3 banks), with a
// read-first and a write-first instance sharing the same stimulus.
module tb_bram_bank_array;

  localparam int W     = 13;
  localparam int NA    = 4;
  localparam int NB    = 3;
  localparam int DEPTH = 16;
  localparam logic [W-1:0] FILL = 13'h1FFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clr = 1'b0;
  logic          wr_en = 1'b0;
  logic [1:0]    wr_bank = '0;
  logic [NA-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          rd_en = 1'b0;
  logic [NA-1:0] rd_addr = '0;

  logic          busy0, busy1, valid0, valid1;
  logic [NB*W-1:0] data0, data1;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bram_bank_array #(.RAM_WIDTH(W), .NB_ADDRESS(NA), .NB_BANKS(NB), .RD_MODE(0)) dut0 (
    .i_CLK(clk), .i_rst(rst_n), .i_clear(clr), .o_busy(busy0),
    .i_wrEnable(wr_en), .i_wrBank(wr_bank), .i_writeAdd(wr_addr), .i_data(wr_data),
    .i_rdEnable(rd_en), .i_readAdd(rd_addr), .o_data(data0), .o_valid(valid0)
  );

  bram_bank_array #(.RAM_WIDTH(W), .NB_ADDRESS(NA), .NB_BANKS(NB), .RD_MODE(1)) dut1 (
    .i_CLK(clk), .i_rst(rst_n), .i_clear(clr), .o_busy(busy1),
    .i_wrEnable(wr_en), .i_wrBank(wr_bank), .i_writeAdd(wr_addr), .i_data(wr_data),
    .i_rdEnable(rd_en), .i_readAdd(rd_addr), .o_data(data1), .o_valid(valid1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory contents, remaining fill cycles, expected outputs.
  logic [W-1:0]    mem [NB][DEPTH];
  int              remaining = DEPTH;
  logic            exp_valid = 1'b0;
  logic [NB*W-1:0] exp_data0 = '0;
  logic [NB*W-1:0] exp_data1 = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        remaining = DEPTH;
        exp_valid = 1'b0;
        exp_data0 = '0;
        exp_data1 = '0;
      end else if (remaining > 0) begin
        exp_valid = 1'b0;
        if (clr) remaining = DEPTH;
        else begin
          remaining--;
          if (remaining == 0)
            for (int b = 0; b < NB; b++)
              for (int a = 0; a < DEPTH; a++) mem[b][a] = FILL;
        end
      end else begin
        exp_valid = rd_en;
        if (rd_en) begin
          for (int b = 0; b < NB; b++) begin
            exp_data0[b*W +: W] = mem[b][rd_addr];
            if (wr_en && !clr && int'(wr_bank) == b && wr_addr == rd_addr)
              exp_data1[b*W +: W] = wr_data;
            else
              exp_data1[b*W +: W] = mem[b][rd_addr];
          end
        end
        if (wr_en && !clr && int'(wr_bank) < NB) mem[wr_bank][wr_addr] = wr_data;
        if (clr) remaining = DEPTH;
      end
    end
  end

  // Compare process: every falling edge, both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("busy0", 64'(busy0), 64'(remaining > 0));
        chk("busy1", 64'(busy1), 64'(remaining > 0));
        chk("valid0", 64'(valid0), 64'(exp_valid));
        chk("valid1", 64'(valid1), 64'(exp_valid));
        chk("data0", 64'(data0), 64'(exp_data0));
        chk("data1", 64'(data1), 64'(exp_data1));
      end
    end
  end

  task automatic inputs_idle();
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  // Counts o_busy-high samples, starting at the current falling edge.
  task automatic count_busy(output int n);
    n = 0;
    while (busy0 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;
  logic [NB*W-1:0] lit;

  initial begin
    #3 rst_n = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_busy", 64'(busy0), 64'd1);
    chk("rst_valid", 64'(valid0), 64'd0);
    chk("rst_data", 64'(data0), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Initial fill lasts 16 cycles, then every location reads FILL.
    count_busy(n);
    chk("fill_len", 64'(n), 64'd16);
    lit = {FILL, FILL, FILL};
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1'b1; rd_addr = NA'(a);
      @(negedge clk);
      chk("fill_rd_valid", 64'(valid0), 64'd1);
      chk("fill_rd_data", 64'(data0), 64'(lit));
    end

    // Single-bank write then read.
    rd_en = 1'b0;
    wr_en = 1'b1; wr_bank = 2'd1; wr_addr = 4'd7; wr_data = 13'h0A5;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd7;
    @(negedge clk);
    rd_en = 1'b0;
    lit = {FILL, 13'h0A5, FILL};
    chk("wr_rd_valid", 64'(valid0), 64'd1);
    chk("wr_rd_data", 64'(data0), 64'(lit));
    @(negedge clk);
    chk("wr_rd_valid_drop", 64'(valid0), 64'd0);
    chk("wr_rd_hold", 64'(data0), 64'(lit));

    // Same-address collision on bank 0.
    wr_en = 1'b1; wr_bank = 2'd0; wr_addr = 4'd3; wr_data = 13'h012;
    rd_en = 1'b1; rd_addr = 4'd3;
    @(negedge clk);
    inputs_idle();
    lit = {FILL, FILL, FILL};
    chk("coll_rdfirst", 64'(data0), 64'(lit));
    lit = {FILL, FILL, 13'h012};
    chk("coll_wrfirst", 64'(data1), 64'(lit));

    // Out-of-range bank select changes nothing.
    wr_en = 1'b1; wr_bank = 2'd3; wr_addr = 4'd5; wr_data = 13'h155;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd5;
    @(negedge clk);
    rd_en = 1'b0;
    lit = {FILL, FILL, FILL};
    chk("bad_bank", 64'(data0), 64'(lit));

    // Random traffic including occasional clears.
    for (int i = 0; i < 400; i++) begin
      clr     = ($urandom_range(0, 63) == 0);
      wr_en   = 1'($urandom);
      wr_bank = 2'($urandom_range(0, 3));
      wr_addr = NA'($urandom_range(0, DEPTH - 1));
      wr_data = W'($urandom);
      rd_en   = clr ? 1'b0 : 1'($urandom);
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : NA'($urandom_range(0, DEPTH - 1));
      @(negedge clk);
    end
    inputs_idle();
    n = 0;
    while (busy0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(busy0), 64'd0);

    // Clear from idle, then restart the fill at counter 9.
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (9) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n = 0;
    while (busy0 && n < 100) begin
      n++;
      chk("busy_valid", 64'(valid0), 64'd0);
      wr_en = 1'($urandom); wr_bank = 2'($urandom_range(0, 2));
      wr_addr = NA'($urandom_range(0, DEPTH - 1)); wr_data = W'($urandom);
      rd_en = 1'($urandom); rd_addr = NA'($urandom_range(0, DEPTH - 1));
      @(negedge clk);
    end
    inputs_idle();
    chk("clear9_len", 64'(n), 64'd16);

    // Asynchronous reset in the middle of a read burst.
    for (int a = 0; a < 4; a++) begin
      rd_en = 1'b1; rd_addr = NA'(a);
      @(negedge clk);
    end
    chk("burst_valid", 64'(valid0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid0", 64'(valid0), 64'd0);
    chk("arst_data0", 64'(data0), 64'd0);
    chk("arst_valid1", 64'(valid1), 64'd0);
    chk("arst_data1", 64'(data1), 64'd0);
    chk("arst_busy", 64'(busy0), 64'd1);
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(n);
    chk("refill_len", 64'(n), 64'd16);
    lit = {FILL, FILL, FILL};
    for (int a = 3; a < 6; a++) begin
      rd_en = 1'b1; rd_addr = NA'(a);
      @(negedge clk);
      chk("refill_rd", 64'(data1), 64'(lit));
    end
    inputs_idle();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
